// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding, zero-divisor
// result constant and the default datapath width.
package div_unit_pkg;

  localparam int unsigned DivWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

  // Every quotient bit is set on a zero divisor; the remainder is the raw dividend.
  localparam logic DivZeroQuoBit = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left by one,
// trial-subtract the divisor and keep the difference when it does not go negative.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // rem < divisor on entry, so a clear top bit means shifted >= divisor
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: restoring divide on magnitudes with
// sign fixup. Define DIV_EARLY_ZERO_EN to finish a zero-divisor divide in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  input  logic             accept,
  output logic             stall_req,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [WIDTH-1:0] rem_q, quo_q, div_q, a_raw_q;
  logic [CntW-1:0]  cnt_q;
  logic             a_neg_q, q_neg_q, b_zero_q;

  logic             a_msb, b_msb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_n, quo_n, quo_fix, rem_fix;

  assign a_msb = sign & a[WIDTH-1];
  assign b_msb = sign & b[WIDTH-1];
  assign abs_a = a_msb ? -a : a;
  assign abs_b = b_msb ? -b : b;

  assign stall_req = ~annul & (((state == StIdle) & start) | (state == StCalc));

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (div_q),
    .rem_next(rem_n),
    .quo_next(quo_n)
  );

  always_comb begin
    quo_fix = q_neg_q ? -quo_n : quo_n;
    rem_fix = a_neg_q ? -rem_n : rem_n;
    if (b_zero_q) begin
      quo_fix = {WIDTH{DivZeroQuoBit}};
      rem_fix = a_raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      a_raw_q   <= '0;
      cnt_q     <= '0;
      a_neg_q   <= 1'b0;
      q_neg_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (annul) begin
      state <= StIdle;
      valid <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            rem_q    <= '0;
            quo_q    <= abs_a;
            div_q    <= abs_b;
            a_raw_q  <= a;
            a_neg_q  <= a_msb;
            q_neg_q  <= a_msb ^ b_msb;
            b_zero_q <= (b == '0);
            cnt_q    <= CntW'(WIDTH);
`ifdef DIV_EARLY_ZERO_EN
            if (b == '0) begin
              state     <= StDone;
              valid     <= 1'b1;
              quotient  <= {WIDTH{DivZeroQuoBit}};
              remainder <= a;
            end else begin
              state <= StCalc;
            end
`else
            state <= StCalc;
`endif
          end
        end
        StCalc: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state     <= StDone;
            valid     <= 1'b1;
            quotient  <= quo_fix;
            remainder <= rem_fix;
          end
        end
        StDone: begin
          if (accept) begin
            state <= StIdle;
            valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed cases plus random divides checked
// against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, sign, annul, accept;
  logic [31:0] a, b;
  logic        stall_req, valid;
  logic [31:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .a        (a),
    .b        (b),
    .annul    (annul),
    .accept   (accept),
    .stall_req(stall_req),
    .valid    (valid),
    .quotient (quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: 64-bit signed arithmetic keeps INT_MIN / -1 well defined.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t   e;
    longint sx, sy;
    if (y == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = x;
    end else if (s) begin
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      e.q = 32'(sx / sy);
      e.r = 32'(sx % sy);
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    return e;
  endfunction

  // Monitor: every consumed result is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid && accept) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got q=0x%08h r=0x%08h expected no result", quotient,
                   remainder);
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
        end
      end
    end
  end

  // Called just after a rising edge in an IDLE cycle; returns just after a rising edge.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                        input int hold);
    exp_t e;
    int   vcyc, scnt, lat;
    e = model(ta, tbv, ts);
    sb.push_back(e);
    lat = 33;
`ifdef DIV_EARLY_ZERO_EN
    if (tbv == 32'd0) lat = 1;
`endif
    start  = 1'b1;
    sign   = ts;
    a      = ta;
    b      = tbv;
    accept = (hold == 0);
    vcyc   = -1;
    scnt   = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (stall_req) scnt++;
      if (valid) begin
        vcyc = c;
        break;
      end
      @(posedge clk);
      #1;
      // Operands are only sampled in IDLE; scramble them meanwhile.
      a    = $urandom;
      b    = $urandom;
      sign = 1'($urandom);
    end
    chk_int("valid_cycle", vcyc, lat);
    chk_int("stall_cycles", scnt, lat);
    if (vcyc < 0) begin
      sb.delete();
      rst   = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk_int("hold_valid", int'(valid), 1);
      chk_int("hold_stall", int'(stall_req), 0);
      chk("hold_quotient", quotient, e.q);
      chk("hold_remainder", remainder, e.r);
      @(posedge clk);
      #1;
      if (h == hold - 1) accept = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk_int("idle_after_accept", int'(valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          pick;
    rst    = 1'b1;
    start  = 1'b0;
    sign   = 1'b0;
    a      = '0;
    b      = '0;
    annul  = 1'b0;
    accept = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("reset_stall", int'(stall_req), 0);
    chk_int("reset_valid", int'(valid), 0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    run_op(32'h8000_0007, 32'd0, 1'b1, 0);

    // Annul in cycle 10 kills the op; a new divide starts in cycle 11.
    start  = 1'b1;
    sign   = 1'b0;
    a      = 32'd1000;
    b      = 32'd3;
    accept = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk_int("annul_no_valid", int'(valid), 0);
      if (c == 10) begin
        chk_int("annul_stall", int'(stall_req), 0);
      end else begin
        @(posedge clk);
        #1;
        if (c == 9) annul = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    annul = 1'b0;
    run_op(32'd9, 32'd4, 1'b0, 0);

    run_op(32'd50, 32'd8, 1'b0, 5);

    // Reset in the middle of a divide clears everything.
    start = 1'b1;
    sign  = 1'b0;
    a     = 32'd12345;
    b     = 32'd17;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_int("midreset_valid", int'(valid), 0);
    chk_int("midreset_stall", int'(stall_req), 0);
    chk("midreset_quotient", quotient, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      ra   = $urandom;
      pick = $urandom_range(0, 7);
      case (pick)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    chk_int("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the EX stage, serving DIV/DIVU, whose results are written to HI/LO. It is started when the controller's EX-stage decode selects a divide. While it works, it holds a stall request to the hazard unit. It delivers quotient (LO) and remainder (HI) through a valid/accept handshake, and it is aborted by pipeline flushes and exceptions.

## Interface
Parameters:
- WIDTH, 32, operand/result width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds a DIV/DIVU; level, held high while the instruction sits in EX.
- sign  in  1  1 = DIV (signed), 0 = DIVU; sampled with start in IDLE.
- a  in  WIDTH  dividend (rs), sampled in IDLE.
- b  in  WIDTH  divisor (rt), sampled in IDLE.
- annul  in  1  flush or exception kills the EX instruction; abort.
- accept  in  1  EX advancing (~StallE); consumes result in DONE.
- stall_req  out  1  to hazard unit: freeze IF/ID/EX.
- valid  out  1  quotient/remainder are valid.
- quotient  out  WIDTH  LO write value.
- remainder  out  WIDTH  HI write value.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - On start & ~annul: latch |a|, |b|, the sign of a, the sign of a XOR the sign of b, b==0, and the raw a.
  - Load the iteration counter with WIDTH and go to CALC.
- CALC:
  - One restoring step per cycle.
  - Shift {rem, quo} left by one. Trial-subtract |b| from rem. If the result is non-negative, keep it and set the quotient LSB to 1.
  - Decrement the counter. When the counter reaches 1, go to DONE.
- DONE:
  - Drive the final results with valid=1.
  - Hold all results stable until accept=1, then go to IDLE.
- Sign fixup (DIV only):
  - Negate the quotient if the operand signs differ.
  - Give the remainder the dividend's sign.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. Operands are unsigned magnitudes, so no special path is needed.
- Divide-by-zero (both signs): quotient all-ones, remainder = raw a. This overrides the fixup.
- The counter is $clog2(WIDTH)+1 bits wide. The remainder datapath is WIDTH+1 bits for the trial subtract.
- stall_req = ~annul & ((state==IDLE & start) | state==CALC). It is low in DONE.
- annul has priority over start and accept in every state: next state IDLE, valid never asserted for the killed op.
- Reset state:
  - State: IDLE.
  - Outputs: stall_req=0, valid=0, quotient=0, remainder=0.
  - Internal: all internal registers cleared.
- Reset mid-operation behaves as annul.

## Timing
- Start sampled in cycle 0.
- CALC occupies cycles 1..WIDTH.
- valid rises in cycle WIDTH+1.
- stall_req is high in cycles 0..WIDTH (WIDTH+1 cycles).
- Results are registered. No combinational path from a/b to quotient/remainder.
- If accept=0 in DONE (stall from elsewhere), DONE persists with valid=1. No restart occurs even though start is still high.
- On accept in DONE, the next cycle is IDLE. A back-to-back divide in the following EX cycle starts normally.
- start is ignored in CALC and DONE.
- annul in cycle k takes effect at edge k; stall_req is low in cycle k itself.

## Configuration
- DIV_EARLY_ZERO_EN defined: when b==0 in IDLE, go directly to DONE.
  - valid is high in cycle 1.
  - stall_req is high only in cycle 0.
  - Results follow the divide-by-zero rule.
- Undefined: a zero divisor runs the full WIDTH iterations with the same final results and standard latency.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, CALC, DONE);
  - the divide-by-zero result constants;
  - the WIDTH default.
- Sub-module div_step is combinational: one restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in CALC.

## Test plan
- DIVU 100/7, accept=1:
  - valid in cycle 33; quotient=14, remainder=2.
  - stall_req high exactly cycles 0..32.
- DIV 0xFFFFFFF9 (−7) / 2:
  - quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF:
  - quotient=0x80000000, remainder=0, no hang.
- DIVU 5/0:
  - quotient=0xFFFFFFFF, remainder=5.
  - valid in cycle 1 with DIV_EARLY_ZERO_EN, cycle 33 without.
- DIVU 1000/3 with annul pulsed in cycle 10:
  - stall_req low in cycle 10; IDLE at cycle 11; valid never rises.
  - A new DIVU 9/4 started in cycle 11 yields quotient=2, remainder=1.
- DIVU 50/8 with accept=0 for 5 cycles in DONE and start held high:
  - valid and results (6, 2) stable throughout; no restart.
  - IDLE one cycle after accept=1.
